// File: rtl/pow_5_result_display.sv
// rtl/pow_5_result_display.sv - 8-digit multiplexed seven-segment driver for the pow_5 result bus
// Optional leading-zero blanking is enabled by defining POW_5_DISP_LEADING_ZERO_BLANK_EN.
module pow_5_result_display #(
  parameter int unsigned div_w = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disp,
  input  logic [7:0]  disp_en,
  input  logic [7:0]  disp_dot,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  // Prescaler value one clock before the slot-ending tick.
  localparam logic [div_w-1:0] CNT_PRE = ~div_w'(1);

  logic [div_w-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      sh_disp_q, sh_disp_d;
  logic [7:0]       sh_en_q, sh_en_d;
  logic [7:0]       sh_dot_q, sh_dot_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             snap;
  logic [7:0]       eff_en;
  logic [7:0]       eff_dot;
  logic [3:0]       cur_nib;
  logic             cur_en;

  assign tick = &cnt_q;
  assign snap = tick && (idx_q == 3'd7);

  // Active-low hex decode, segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef POW_5_DISP_LEADING_ZERO_BLANK_EN
  logic [7:0] lz_mask;

  // Digit i blanks when it and every more significant nibble are zero; digit 0 always shows.
  always_comb begin
    lz_mask = 8'h00;
    for (int i = 1; i < 8; i++) begin
      lz_mask[i] = ((disp >> (4 * i)) == 32'd0);
    end
    eff_en  = disp_en & ~lz_mask;
    eff_dot = disp_dot & ~lz_mask;
  end
`else
  // Enables and dots pass straight through to the snapshot.
  always_comb begin
    eff_en  = disp_en;
    eff_dot = disp_dot;
  end
`endif

  // Next-state for prescaler, scan index, snapshot and registered outputs.
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    sh_disp_d = snap ? disp    : sh_disp_q;
    sh_en_d   = snap ? eff_en  : sh_en_q;
    sh_dot_d  = snap ? eff_dot : sh_dot_q;
    frame_d   = (cnt_q == CNT_PRE) && (idx_q == 3'd7);

    cur_nib   = sh_disp_q[{idx_q, 2'b00} +: 4];
    cur_en    = sh_en_q[idx_q];
    if (cur_en) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = hex7(cur_nib);
      dp_d  = ~sh_dot_q[idx_q];
    end else begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  // All state; reset blanks the display and clears the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      sh_disp_q <= 32'h0;
      sh_en_q   <= 8'h00;
      sh_dot_q  <= 8'h00;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_disp_q <= sh_disp_d;
      sh_en_q   <= sh_en_d;
      sh_dot_q  <= sh_dot_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_pow_5_result_display.sv
// tb/tb_pow_5_result_display.sv - randomized self-checking bench for pow_5_result_display
module tb_pow_5_result_display;

  localparam int DIV_W = 2;
  localparam int PER   = 1 << DIV_W;
  localparam int FRM   = 8 * PER;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] disp = 32'h0;
  logic [7:0]  disp_en = 8'h00;
  logic [7:0]  disp_dot = 8'h00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int n_cmp = 0;
  int n_err = 0;

  // Model: clocks since reset release and the last snapshot taken.
  int          t = 0;
  logic [31:0] m_disp = 32'h0;
  logic [7:0]  m_en = 8'h00;
  logic [7:0]  m_dot = 8'h00;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_frame;

  pow_5_result_display #(.div_w(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .disp(disp), .disp_en(disp_en), .disp_dot(disp_dot),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    t = 0;
    m_disp = 32'h0;
    m_en = 8'h00;
    m_dot = 8'h00;
  endtask

  // Predict the outputs after the next rising edge, then advance one clock.
  task automatic step();
    int tn;
    int d;
    logic [7:0] mask;
    tn = t + 1;
    d = (t / PER) % 8;
    if (m_en[d]) begin
      exp_an  = 8'hFF - (8'd1 << d);
      exp_seg = SEG_TBL[(m_disp >> (4 * d)) % 16];
      exp_dp  = !m_dot[d];
    end else begin
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end
    exp_frame = ((tn % FRM) == FRM - 1);
    if ((tn % FRM) == 0) begin
      mask = 8'h00;
`ifdef POW_5_DISP_LEADING_ZERO_BLANK_EN
      for (int i = 1; i < 8; i++) if ((disp >> (4 * i)) == 0) mask[i] = 1'b1;
`endif
      m_disp = disp;
      m_en   = disp_en & ~mask;
      m_dot  = disp_dot & ~mask;
    end
    @(posedge clk);
    #1;
    t = tn;
  endtask

  task automatic test_reset();
    disp = 32'h0; disp_en = 8'hFF; disp_dot = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, dp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state an=%h seg=%h dp=%b frame=%b expected an=ff seg=7f dp=1 frame=0", an, seg, dp, frame);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    repeat (2 * FRM + 5) begin
      step();
      n_cmp++;
      if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_err++;
        $display("FAIL reset_release t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                 t, an, seg, dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  task automatic test_pattern();
    disp = 32'h89AB_CDEF; disp_en = 8'hFF; disp_dot = 8'h01;
    repeat (2 * FRM) begin
      step();
      n_cmp++;
      if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_err++;
        $display("FAIL pattern t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                 t, an, seg, dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  task automatic test_enable();
    disp = 32'h89AB_CDEF; disp_en = 8'h0F; disp_dot = 8'h01;
    repeat (2 * FRM) begin
      step();
      n_cmp++;
      if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_err++;
        $display("FAIL enable t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                 t, an, seg, dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  task automatic test_midframe();
    int n;
    disp = 32'h1111_1111; disp_en = 8'hFF; disp_dot = 8'h00;
    n = FRM + ((FRM - (t % FRM)) % FRM) + 3 * PER;
    repeat (n + 2 * FRM) begin
      if (n == 0) disp = 32'h2222_2222;
      n--;
      step();
      n_cmp++;
      if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_err++;
        $display("FAIL midframe t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                 t, an, seg, dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  task automatic test_reset_mid();
    disp = 32'h5A5A_5A5A; disp_en = 8'hFF; disp_dot = 8'hFF;
    repeat (FRM + ((FRM - (t % FRM)) % FRM) + 5 * PER + 1) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, dp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid an=%h seg=%h dp=%b frame=%b expected an=ff seg=7f dp=1 frame=0", an, seg, dp, frame);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    repeat (FRM + PER + 2) begin
      step();
      n_cmp++;
      if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_err++;
        $display("FAIL reset_restart t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                 t, an, seg, dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  task automatic test_zero_blank();
    disp = 32'h0000_0300; disp_en = 8'hFF; disp_dot = 8'hFF;
    repeat (2 * FRM) begin
      step();
      n_cmp++;
      if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_err++;
        $display("FAIL zero_blank t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                 t, an, seg, dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
    disp = 32'h0;
    repeat (2 * FRM) begin
      step();
      n_cmp++;
      if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_err++;
        $display("FAIL zero_all t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                 t, an, seg, dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  task automatic test_random();
    repeat (12 * FRM) begin
      if ($urandom_range(0, 7) == 0) begin
        disp     = $urandom >> (4 * $urandom_range(0, 7));
        disp_en  = 8'($urandom);
        disp_dot = 8'($urandom);
      end
      step();
      n_cmp++;
      if ({an, seg, dp, frame} !== {exp_an, exp_seg, exp_dp, exp_frame}) begin
        n_err++;
        $display("FAIL random t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                 t, an, seg, dp, frame, exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_enable();
    test_midframe();
    test_reset_mid();
    test_zero_blank();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
